// File: rtl/game_timebase_if.sv
// Strobe/readback bundle between the game-control FSM and its timebase.
interface game_timebase_if;
    logic       enable_countdown;
    logic       clear_countdown;
    logic       enable_game_timer;
    logic       clear_game_timer;
    logic [5:0] countdown_sec;
    logic [5:0] game_time_sec;
    logic       countdown_tick;
    logic       game_tick;
    logic       blink;

    // Control side: drives enables/clears, reads the second counts
    modport master (
        output enable_countdown, clear_countdown,
        output enable_game_timer, clear_game_timer,
        input  countdown_sec, game_time_sec,
        input  countdown_tick, game_tick, blink
    );

    // Timebase side
    modport slave (
        input  enable_countdown, clear_countdown,
        input  enable_game_timer, clear_game_timer,
        output countdown_sec, game_time_sec,
        output countdown_tick, game_tick, blink
    );
endinterface

// File: rtl/game_timebase.sv
// Two independent saturating seconds counters, each with its own prescaler,
// plus a free-running 1 Hz blink square wave. All outputs registered.
// Channel 0 = countdown, channel 1 = game timer.
module game_timebase #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SEC_MAX = 63
) (
    input  logic            clk,
    input  logic            rst_n,
    game_timebase_if.slave  bus
);
    localparam int             PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  HALF_LAST = PW'(CLK_HZ / 2 - 1);
    localparam logic [5:0]     SEC_SAT   = 6'(SEC_MAX);

    logic [1:0]    w_en;
    logic [1:0]    w_clr;
    logic [PW-1:0] r_pre [2];
    logic [5:0]    r_sec [2];
    logic [1:0]    r_tick;
    logic [PW-1:0] r_blink_pre;
    logic          r_blink;

    assign w_en  = {bus.enable_game_timer, bus.enable_countdown};
    assign w_clr = {bus.clear_game_timer,  bus.clear_countdown};

    // Per-channel prescaler and seconds counter; clear beats enable, and a
    // paused channel keeps its prescaler phase so the second resumes intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                r_pre[c]  <= '0;
                r_sec[c]  <= '0;
                r_tick[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_clr[c]) begin
                    r_pre[c]  <= '0;
                    r_sec[c]  <= '0;
                    r_tick[c] <= 1'b0;
                end else if (w_en[c]) begin
                    if (r_pre[c] == PRE_LAST) begin
                        r_pre[c]  <= '0;
                        r_tick[c] <= 1'b1;
                        if (r_sec[c] != SEC_SAT) begin
                            r_sec[c] <= r_sec[c] + 6'd1;
                        end
                    end else begin
                        r_pre[c]  <= r_pre[c] + 1'b1;
                        r_tick[c] <= 1'b0;
                    end
                end else begin
                    r_tick[c] <= 1'b0;
                end
            end
        end
    end

    // Free-running half-second prescaler toggling blink; first rise lands
    // CLK_HZ/2 edges after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_pre <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_pre == HALF_LAST) begin
            r_blink_pre <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_pre <= r_blink_pre + 1'b1;
        end
    end

    assign bus.countdown_sec  = r_sec[0];
    assign bus.game_time_sec  = r_sec[1];
    assign bus.countdown_tick = r_tick[0];
    assign bus.game_tick      = r_tick[1];
    assign bus.blink          = r_blink;
endmodule

// File: tb/tb_game_timebase.sv
// Bench for game_timebase: directed scenarios followed by random enable/clear
// traffic, every cycle compared against an arithmetic model. Two DUTs share
// the stimulus: one with SEC_MAX=63, one with SEC_MAX=3 for saturation.
module tb_game_timebase;
    localparam int CLK_HZ = 10;
    localparam int SMAX_A = 63;
    localparam int SMAX_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en  [2];
    logic clr [2];

    int n_cmp = 0;
    int n_bad = 0;

    // model: enabled cycles since clear per channel, edges since reset
    int m_cnt  [2];
    int m_tick [2];
    int m_edges;

    game_timebase_if bus_a ();
    game_timebase_if bus_b ();

    assign bus_a.enable_countdown  = en[0];
    assign bus_a.clear_countdown   = clr[0];
    assign bus_a.enable_game_timer = en[1];
    assign bus_a.clear_game_timer  = clr[1];
    assign bus_b.enable_countdown  = en[0];
    assign bus_b.clear_countdown   = clr[0];
    assign bus_b.enable_game_timer = en[1];
    assign bus_b.clear_game_timer  = clr[1];

    game_timebase #(.CLK_HZ(CLK_HZ), .SEC_MAX(SMAX_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    game_timebase #(.CLK_HZ(CLK_HZ), .SEC_MAX(SMAX_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_sec(input int ch, input int smax);
        int s;
        s = m_cnt[ch] / CLK_HZ;
        return (s > smax) ? smax : s;
    endfunction

    function automatic int exp_blink();
        return (m_edges / (CLK_HZ / 2)) % 2;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c]  = 0;
            m_tick[c] = 0;
        end
        m_edges = 0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) begin
                m_cnt[c]  = 0;
                m_tick[c] = 0;
            end else if (en[c]) begin
                m_cnt[c]++;
                m_tick[c] = (m_cnt[c] % CLK_HZ == 0) ? 1 : 0;
            end else begin
                m_tick[c] = 0;
            end
        end
        m_edges++;
    endtask

    task automatic check_all();
        chk("a_cd_sec",   int'(bus_a.countdown_sec),  exp_sec(0, SMAX_A));
        chk("a_gm_sec",   int'(bus_a.game_time_sec),  exp_sec(1, SMAX_A));
        chk("a_cd_tick",  int'(bus_a.countdown_tick), m_tick[0]);
        chk("a_gm_tick",  int'(bus_a.game_tick),      m_tick[1]);
        chk("a_blink",    int'(bus_a.blink),          exp_blink());
        chk("b_cd_sec",   int'(bus_b.countdown_sec),  exp_sec(0, SMAX_B));
        chk("b_gm_sec",   int'(bus_b.game_time_sec),  exp_sec(1, SMAX_B));
        chk("b_cd_tick",  int'(bus_b.countdown_tick), m_tick[0]);
        chk("b_gm_tick",  int'(bus_b.game_tick),      m_tick[1]);
        chk("b_blink",    int'(bus_b.blink),          exp_blink());
    endtask

    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            en[c]  = 1'b0;
            clr[c] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // count a while, then assert reset mid-run
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
        en[0] = 1'b1; en[1] = 1'b1;
        step(23);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_cd_sec",  int'(bus_a.countdown_sec),  0);
        chk("rst_gm_sec",  int'(bus_a.game_time_sec),  0);
        chk("rst_cd_tick", int'(bus_a.countdown_tick), 0);
        chk("rst_blink",   int'(bus_a.blink),          0);
        en[0] = 1'b0; en[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(50);
        chk("idle_cd_sec", int'(bus_a.countdown_sec), 0);
        chk("idle_gm_sec", int'(bus_a.game_time_sec), 0);

        // plain counting: ticks at enabled cycles 10..50
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
        en[0] = 1'b1;
        step(50);
        chk("count_cd_sec", int'(bus_a.countdown_sec), 5);
        en[0] = 1'b0;

        // clear beats enable
        clr[1] = 1'b1; en[1] = 1'b1;
        step(25);
        chk("clrpri_gm_sec", int'(bus_a.game_time_sec), 0);
        clr[1] = 1'b0;
        step(9);
        chk("clrpri_gm_9", int'(bus_a.game_time_sec), 0);
        step(1);
        chk("clrpri_gm_10", int'(bus_a.game_time_sec), 1);
        chk("clrpri_tick",  int'(bus_a.game_tick),     1);
        en[1] = 1'b0;

        // pause keeps prescaler phase
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
        en[0] = 1'b1; step(7);
        en[0] = 1'b0; step(30);
        en[0] = 1'b1; step(2);
        chk("pause_cd_2", int'(bus_a.countdown_sec), 0);
        step(1);
        chk("pause_cd_3", int'(bus_a.countdown_sec), 1);
        en[0] = 1'b0;

        // saturation on the SEC_MAX=3 instance
        clr[1] = 1'b1; step(1); clr[1] = 1'b0;
        en[1] = 1'b1;
        step(60);
        chk("sat_b_gm_sec", int'(bus_b.game_time_sec), 3);
        chk("sat_a_gm_sec", int'(bus_a.game_time_sec), 6);

        // independence: clear game channel while countdown runs
        en[0] = 1'b1;
        step(4);
        clr[1] = 1'b1; step(3); clr[1] = 1'b0;
        step(20);
        en[0] = 1'b0; en[1] = 1'b0;

        // random traffic, long enough to saturate SEC_MAX=63 on some runs
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < 2; c++) begin
                en[c]  = ($urandom_range(7, 0) != 0);
                clr[c] = ($urandom_range(200, 0) == 0);
            end
            step(1);
        end
        for (int c = 0; c < 2; c++) begin
            en[c]  = 1'b1;
            clr[c] = 1'b0;
        end
        step(700);
        chk("long_a_cd_sec", int'(bus_a.countdown_sec), 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
